// File: rtl/input_debouncer.sv
// Debounces one noisy asynchronous level input into a clean level on CLK,
// with single-cycle RISE/FALL pulses on every accepted transition.
module input_debouncer #(
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic CLK,
    input  logic RST,
    input  logic IN,
    output logic OUT,
    output logic RISE,
    output logic FALL
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_in;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   out_reg;
    logic                   out_next;
    logic                   rise_next;
    logic                   fall_next;
    logic                   rise_reg;
    logic                   fall_reg;

    // IN is only ever touched by the first synchronizer stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_reg <= '0;
        end else begin
            sync_reg[0] <= IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign sync_in = sync_reg[SYNC_STAGES-1];

    // Counter saturates at CNT_LAST, where the output flips and it restarts.
    always_comb begin
        cnt_next  = '0;
        out_next  = out_reg;
        rise_next = 1'b0;
        fall_next = 1'b0;
        if (sync_in != out_reg) begin
            if (cnt_reg == CNT_LAST) begin
                out_next  = sync_in;
                rise_next = sync_in;
                fall_next = ~sync_in;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_reg  <= '0;
            out_reg  <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            out_reg  <= out_next;
            rise_reg <= rise_next;
            fall_reg <= fall_next;
        end
    end

    assign OUT  = out_reg;
    assign RISE = rise_reg;
    assign FALL = fall_reg;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with STABLE_CYCLES=16, SYNC_STAGES=2.
module tb_input_debouncer;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic IN  = 1'b0;
    logic OUT;
    logic RISE;
    logic FALL;

    int checks   = 0;
    int errors   = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    input_debouncer #(
        .STABLE_CYCLES(16),
        .SYNC_STAGES  (2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .IN  (IN),
        .OUT (OUT),
        .RISE(RISE),
        .FALL(FALL)
    );

    always #5 CLK = ~CLK;

    // Pulse counting and mutual exclusion, sampled on the falling edge.
    always @(negedge CLK) begin
        if (RISE === 1'b1) rise_cnt++;
        if (FALL === 1'b1) fall_cnt++;
        checks++;
        assert ((RISE & FALL) !== 1'b1) else begin
            errors++;
            $error("FAIL both_pulses observed RISE=%b FALL=%b expected not both 1", RISE, FALL);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
        $display("check %-16s observed %0d expected %0d", tag, observed, expected);
    endtask

    initial begin
        // Reset held with IN toggling: outputs stay quiet.
        RST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            IN = i[0];
            step(1);
            chk("rst_out", OUT, 0);
            chk("rst_rise", RISE, 0);
            chk("rst_fall", FALL, 0);
        end
        IN  = 1'b0;
        RST = 1'b0;
        step(20);
        chk("idle_out", OUT, 0);

        // Clean rise: new level sampled on edge 1, OUT follows on edge 18.
        rise_cnt = 0; fall_cnt = 0;
        IN = 1'b1;
        step(17);
        chk("rise_e17_out", OUT, 0);
        step(1);
        chk("rise_e18_out", OUT, 1);
        chk("rise_e18_pulse", RISE, 1);
        step(1);
        chk("rise_e19_pulse", RISE, 0);
        chk("rise_e19_out", OUT, 1);
        chk("rise_count", rise_cnt, 1);

        // 15-cycle low glitch is one short of acceptance.
        step(5);
        fall_cnt = 0;
        IN = 1'b0;
        step(15);
        IN = 1'b1;
        step(30);
        chk("glitch_out", OUT, 1);
        chk("glitch_fall", fall_cnt, 0);

        // Clean fall.
        fall_cnt = 0;
        IN = 1'b0;
        step(17);
        chk("fall_e17_out", OUT, 1);
        step(1);
        chk("fall_e18_out", OUT, 0);
        chk("fall_e18_pulse", FALL, 1);
        step(1);
        chk("fall_e19_pulse", FALL, 0);
        chk("fall_count", fall_cnt, 1);

        // Bounce: 10 high, 10 low rejected; 20 high accepted on its 18th edge;
        // trailing 5 low rejected.
        step(5);
        rise_cnt = 0; fall_cnt = 0;
        IN = 1'b1; step(10);
        IN = 1'b0; step(10);
        chk("bounce_out_a", OUT, 0);
        IN = 1'b1; step(17);
        chk("bounce_e17_out", OUT, 0);
        step(1);
        chk("bounce_e18_out", OUT, 1);
        step(2);
        IN = 1'b0; step(5);
        IN = 1'b1; step(30);
        chk("bounce_out_b", OUT, 1);
        chk("bounce_rises", rise_cnt, 1);
        chk("bounce_falls", fall_cnt, 0);

        // Reset forcing OUT 1->0 must not pulse FALL.
        fall_cnt = 0;
        IN  = 1'b0;
        RST = 1'b1;
        step(3);
        chk("rst_clr_out", OUT, 0);
        chk("rst_no_fall", fall_cnt, 0);
        RST = 1'b0;
        step(5);

        // Reset mid-count: counter reaches 10 on edge 12, reset sampled on edge 13.
        rise_cnt = 0;
        IN = 1'b1;
        step(12);
        RST = 1'b1;
        step(4);
        chk("midrst_out", OUT, 0);
        chk("midrst_rise", rise_cnt, 0);
        RST = 1'b0;
        step(17);
        chk("midrst_e17_out", OUT, 0);
        chk("midrst_e17_rise", rise_cnt, 0);
        step(1);
        chk("midrst_e18_out", OUT, 1);
        chk("midrst_e18_pulse", RISE, 1);
        step(2);
        chk("midrst_rises", rise_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
